// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO with a valid/ready write port.
// Frames go out back-to-back while words are queued; TxD_o is registered.
module uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_W      = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk_i,
   input  logic                          srst_i,
   input  logic [DATA_W-1:0]             data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          TxD_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int BW           = $clog2(CLKS_PER_BIT);
   localparam int CW           = 4;
   localparam bit ODD          = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              full, empty, push, pop;
   logic [DATA_W-1:0] head;

   state_t            state, state_d;
   logic [BW-1:0]     baud, baud_d;
   logic [CW-1:0]     bit_cnt, bit_d;
   logic [DATA_W-1:0] shreg, shreg_d;
   logic              par_bit, par_d;
   logic              txd, txd_d;
   logic              busy, busy_d;
   logic              bit_end;

   assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty      = (wr_ptr == rd_ptr);
   // ready depends only on state and reset, never on valid_i
   assign ready_o    = !full && !srst_i;
   assign push       = valid_i && ready_o;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign fifo_cnt_o = wr_ptr - rd_ptr;
   assign bit_end    = (baud == BW'(CLKS_PER_BIT - 1));
   assign TxD_o      = txd;
   assign busy_o     = busy;

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         txd     <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         baud    <= baud_d;
         bit_cnt <= bit_d;
         shreg   <= shreg_d;
         par_bit <= par_d;
         txd     <= txd_d;
         busy    <= busy_d;
      end
   end

   always_comb begin
      state_d = state;
      baud_d  = bit_end ? '0 : baud + BW'(1);
      bit_d   = bit_cnt;
      shreg_d = shreg;
      par_d   = par_bit;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg >> 1;
               if (bit_cnt == CW'(DATA_W - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_d = bit_cnt + CW'(1);
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_d = STOP;
               bit_d   = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt == CW'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  if (!empty) begin
                     pop     = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_cnt + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         shreg_d = head;
         par_d   = (^head) ^ ODD;
      end
   end

   // line level is decoded from the next state so the register lands with the transition
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != IDLE);
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg_d[0];
         PAR:     txd_d = par_d;
         default: txd_d = 1'b1;
      endcase
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO and a valid/ready write interface. Generalises the board-level single-shot TX path, which sends one byte per debounced button press. This block accepts a stream of words from any on-chip producer and serialises them back-to-back. Data width, parity, stop bits, baud rate and buffer depth are all configurable. It sits between core logic and the TxD pin. A button-driven shell can still drive it by pulsing valid_i.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115_200, line bit rate. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division); this value must be at least 4.
DATA_W, 8, data bits per frame. Legal values are 5 to 9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits: 1 or 2.
FIFO_DEPTH, 8, FIFO entries. Must be a power of 2 and at least 2.

Ports:
clk_i  in  1  system clock; all logic is on the rising edge.
srst_i  in  1  synchronous reset, active-high.
data_i  in  DATA_W  word to transmit.
valid_i  in  1  data_i is valid.
ready_o  out  1  FIFO can accept a word.
TxD_o  out  1  serial line output; idles high.
busy_o  out  1  a frame is currently on the line.
fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous; srst_i is sampled on clk_i.
  - While srst_i is high: TxD_o=1, busy_o=0, ready_o=0, fifo_cnt_o=0. The FIFO is flushed and the FSM goes to IDLE.
  - ready_o=1 from the first cycle after srst_i falls.
  - Asserting srst_i mid-frame aborts the frame. TxD_o is 1 from the next edge, and all queued words are discarded.
- Write handshake:
  - A word is accepted on a rising edge where valid_i && ready_o.
  - ready_o = !full and is registered-equivalent. It does not depend combinationally on valid_i.
  - When the FIFO is full, ready_o=0 even if the FSM pops in the same cycle. There is no write-through at full.
  - valid_i with ready_o=0 is ignored. Data is not lost from the producer's view because the producer must hold valid_i.
  - A simultaneous push and pop when not full leaves fifo_cnt_o unchanged.
- FIFO: circular buffer with read and write pointers of $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo 2*FIFO_DEPTH.
  - full: pointer indices are equal and the MSBs differ.
  - empty: pointers are equal.
- Baud timer: counts 0 to CLKS_PER_BIT-1. It reloads at each bit boundary, and every line bit lasts exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: if the FIFO is non-empty, at the next edge pop the head into the shift register, compute parity, and go to START.
  - START: TxD_o=0 for one bit time, then go to DATA.
  - DATA: send DATA_W bits LSB first, then go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: even mode sends the XOR of the data bits. Odd mode sends the inverse of that XOR. Then go to STOP.
  - STOP: TxD_o=1 for STOP_BITS bit times. At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- TxD_o is driven from a register, so there are no glitches.
- Latency:
  - A word accepted at edge E0 into an empty FIFO with the FSM in IDLE is popped at edge E1. TxD_o falls at E1.
  - busy_o rises at E1. It falls at the edge that ends the last stop bit, and only if no further word follows.
- Frame length = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- fifo_cnt_o is updated on the same edge as each push or pop.

Test Plan:
Use CLK_FREQ_HZ=1_000_000 and BAUD_RATE=100_000 (CLKS_PER_BIT=10) for all scenarios.
1. Default parameters; push 0xA5 once after reset -> TxD_o falls 1 cycle after acceptance and holds each bit 10 cycles. Sequence: 0, 1,0,1,0,0,1,0,1, 1. The frame takes 100 cycles, then busy_o goes to 0.
2. PARITY=2, push 0x07 -> parity bit is 1 and the frame is 110 cycles. PARITY=1, push 0x07 -> parity bit is 0.
3. DATA_W=7, STOP_BITS=2, push 0x55 -> 7 data bits are sent LSB first, followed by 20 high cycles before the next start bit.
4. FIFO_DEPTH=4; hold valid_i high for 6 words 0x01..0x06 while the line is idle -> 5 words are accepted before ready_o drops. The first is popped at once and 4 are queued. All 6 frames go out back-to-back with no idle gap and in order. fifo_cnt_o never exceeds 4.
5. Assert srst_i for 1 cycle at cycle 35 of a frame with 3 words queued -> TxD_o=1 on the next edge and fifo_cnt_o=0. No further start bit appears. ready_o=1 one cycle after the reset ends.
6. Push at full with a simultaneous pop -> the word is not accepted and fifo_cnt_o drops by 1. The next valid_i is accepted in the following cycle.
